// File: rtl/z80_cb_hl_rmw_seq.sv
// Read-modify-write sequencer for the Z80 CB-prefixed rotate/shift group on (HL).
// Optional macro Z80_SLL_EN enables the undocumented SLL (op 110); otherwise op 110 is flagged illegal.
module z80_cb_hl_rmw_seq #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] hl,
    input  logic [7:0]  f_in,
    output logic        busy,
    output logic        done,
    output logic [7:0]  f_out,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        illegal,
    output logic        timeout
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_MOD  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

`ifdef Z80_SLL_EN
    localparam logic SLL_EN = 1'b1;
`else
    localparam logic SLL_EN = 1'b0;
`endif

    logic [2:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  fin_q, fin_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  flags_q, flags_d;
    logic [7:0]  fout_q, fout_d;
    logic [7:0]  wait_q, wait_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic        busy_q, done_q, rd_q, wr_q;

    function automatic logic parity_even(input logic [7:0] v);
        return ~^v;
    endfunction

    function automatic logic [7:0] shift_result(input logic [2:0] o, input logic [7:0] d, input logic c);
        logic [7:0] r;
        case (o)
            3'b000:  r = {d[6:0], d[7]};
            3'b001:  r = {d[0], d[7:1]};
            3'b010:  r = {d[6:0], c};
            3'b011:  r = {c, d[7:1]};
            3'b100:  r = {d[6:0], 1'b0};
            3'b101:  r = {d[7], d[7:1]};
            3'b110:  r = {d[6:0], 1'b1};
            3'b111:  r = {1'b0, d[7:1]};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Odd opcodes shift right and carry out bit 0; even ones shift left and carry out bit 7.
    function automatic logic [7:0] shift_flags(input logic [2:0] o, input logic [7:0] d,
                                               input logic [7:0] r, input logic [7:0] fi);
        logic c;
        c = o[0] ? d[0] : d[7];
        return {r[7], (r == 8'h00), fi[5], 1'b0, fi[3], parity_even(r), 1'b0, c};
    endfunction

    // Next-state and datapath decode.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        fin_d     = fin_q;
        data_d    = data_q;
        wdata_d   = wdata_q;
        flags_d   = flags_q;
        fout_d    = fout_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op;
                    addr_d    = hl;
                    fin_d     = f_in;
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                    wait_d    = 8'd0;
                    if ((op == 3'b110) && !SLL_EN) begin
                        illegal_d = 1'b1;
                        fout_d    = f_in;
                        state_d   = S_FIN;
                    end else begin
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    wait_d  = 8'd0;
                    state_d = S_MOD;
                end else if (wait_q + 8'd1 == WAIT_LIM) begin
                    timeout_d = 1'b1;
                    fout_d    = fin_q;
                    wait_d    = 8'd0;
                    state_d   = S_FIN;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_MOD: begin
                wdata_d = shift_result(op_q, data_q, fin_q[0]);
                flags_d = shift_flags(op_q, data_q, shift_result(op_q, data_q, fin_q[0]), fin_q);
                wait_d  = 8'd0;
                state_d = S_WR;
            end
            S_WR: begin
                if (mem_ack) begin
                    fout_d  = flags_q;
                    wait_d  = 8'd0;
                    state_d = S_FIN;
                end else if (wait_q + 8'd1 == WAIT_LIM) begin
                    timeout_d = 1'b1;
                    fout_d    = fin_q;
                    wait_d    = 8'd0;
                    state_d   = S_FIN;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered bus/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= 3'd0;
            addr_q    <= 16'h0000;
            fin_q     <= 8'h00;
            data_q    <= 8'h00;
            wdata_q   <= 8'h00;
            flags_q   <= 8'h00;
            fout_q    <= 8'h00;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            fin_q     <= fin_d;
            data_q    <= data_d;
            wdata_q   <= wdata_d;
            flags_q   <= flags_d;
            fout_q    <= fout_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_FIN);
            rd_q      <= (state_d == S_RD);
            wr_q      <= (state_d == S_WR);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign f_out     = fout_q;
    assign mem_addr  = addr_q;
    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;
    assign mem_wdata = wdata_q;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_z80_cb_hl_rmw_seq.sv
// Randomised self-checking bench for z80_cb_hl_rmw_seq against an arithmetic reference model.
// Honours Z80_SLL_EN the same way as the design.
module tb_z80_cb_hl_rmw_seq;

    localparam int MW = 4;

`ifdef Z80_SLL_EN
    localparam bit SLL_EN = 1'b1;
`else
    localparam bit SLL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] hl = 16'h0000;
    logic [7:0]  f_in = 8'h00;
    logic        busy, done, mem_rd, mem_wr, illegal, timeout;
    logic [7:0]  f_out, mem_wdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    z80_cb_hl_rmw_seq #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .hl(hl), .f_in(f_in),
        .busy(busy), .done(done), .f_out(f_out), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result using integer arithmetic on the byte value.
    function automatic int ref_result(input int o, input int d, input int c);
        case (o)
            0: return ((d * 2) % 256) + (d / 128);
            1: return (d / 2) + (d % 2) * 128;
            2: return ((d * 2) % 256) + c;
            3: return (d / 2) + c * 128;
            4: return (d * 2) % 256;
            5: return (d / 2) + ((d >= 128) ? 128 : 0);
            6: return ((d * 2) % 256) + 1;
            default: return d / 2;
        endcase
    endfunction

    function automatic int ref_flags(input int o, input int d, input int r, input int fi);
        int ones = 0;
        int cy;
        for (int b = 0; b < 8; b++) ones += (r >> b) & 1;
        cy = (o % 2 == 0) ? ((d >= 128) ? 1 : 0) : (d % 2);
        return ((r >= 128) ? 128 : 0) + ((r == 0) ? 64 : 0) + (fi & 'h28)
             + ((ones % 2 == 0) ? 4 : 0) + cy;
    endfunction

    task automatic run_txn(input string nm, input logic [2:0] t_op, input logic [15:0] t_hl,
                           input logic [7:0] t_f, input logic [7:0] t_mem,
                           input int rd_dly, input int wr_dly, input bit poke);
        int  r, fl, exp_done, k, done_k, rdc, wrc;
        bit  ill, exp_to, exp_rd, exp_wr, both_bad, addr_bad, wd_bad, got;
        logic [7:0] wd_first, exp_f;
        ill = (t_op == 3'd6) && !SLL_EN;
        r   = ref_result(int'(t_op), int'(t_mem), int'(t_f[0]));
        fl  = ref_flags(int'(t_op), int'(t_mem), r, int'(t_f));
        exp_to = 1'b0; exp_rd = 1'b1; exp_wr = 1'b1; exp_f = 8'(fl);
        if (ill) begin
            exp_done = 1; exp_rd = 1'b0; exp_wr = 1'b0; exp_f = t_f;
        end else if (rd_dly >= MW) begin
            exp_done = MW + 1; exp_to = 1'b1; exp_wr = 1'b0; exp_f = t_f;
        end else if (wr_dly >= MW) begin
            exp_done = rd_dly + MW + 3; exp_to = 1'b1; exp_f = t_f;
        end else begin
            exp_done = rd_dly + wr_dly + 4;
        end
        rdc = 0; wrc = 0; done_k = -1; got = 1'b0;
        both_bad = 1'b0; addr_bad = 1'b0; wd_bad = 1'b0; wd_first = 8'h00;
        @(negedge clk);
        start = 1'b1; op = t_op; hl = t_hl; f_in = t_f;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!got && k <= 60) begin
            if (mem_rd && mem_wr) both_bad = 1'b1;
            if (busy && mem_addr !== t_hl) addr_bad = 1'b1;
            if (mem_rd) begin
                rdc++;
                mem_ack   = (rdc == rd_dly + 1);
                mem_rdata = t_mem;
            end else if (mem_wr) begin
                wrc++;
                if (wrc == 1) wd_first = mem_wdata;
                else if (mem_wdata !== wd_first) wd_bad = 1'b1;
                mem_ack   = (wrc == wr_dly + 1);
                mem_rdata = 8'($urandom);
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = 8'($urandom);
            end
            start = poke && (k == 2) && busy;
            if (start) begin
                op = ~t_op; hl = ~t_hl; f_in = ~t_f;
            end
            if (done) begin
                done_k = k;
                got = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        mem_ack = 1'b0;
        start   = 1'b0;
        check({nm, "_done_cycle"}, 32'(done_k), 32'(exp_done));
        check({nm, "_illegal"}, 32'(illegal), 32'(ill));
        check({nm, "_timeout"}, 32'(timeout), 32'(exp_to));
        check({nm, "_f_out"}, 32'(f_out), 32'(exp_f));
        check({nm, "_read_seen"}, 32'(rdc > 0), 32'(exp_rd));
        check({nm, "_write_seen"}, 32'(wrc > 0), 32'(exp_wr));
        if (exp_wr) check({nm, "_wdata"}, 32'(wd_first), 32'(r));
        check({nm, "_wdata_stable"}, 32'(wd_bad), 32'd0);
        check({nm, "_rd_wr_excl"}, 32'(both_bad), 32'd0);
        check({nm, "_addr"}, 32'(addr_bad), 32'd0);
        @(negedge clk);
        check({nm, "_done_pulse"}, 32'(done), 32'd0);
        check({nm, "_idle"}, 32'(busy), 32'd0);
        check({nm, "_f_out_hold"}, 32'(f_out), 32'(exp_f));
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [15:0] r_hl;
        logic [7:0]  r_f, r_m;
        int          r_rd, r_wr;
        bit          seen_wr;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_wr", 32'({mem_rd, mem_wr}), 32'd0);
        check("rst_status", 32'({illegal, timeout}), 32'd0);
        check("rst_f_out", 32'(f_out), 32'h00);
        check("rst_addr", 32'(mem_addr), 32'h0000);
        check("rst_wdata", 32'(mem_wdata), 32'h00);
        reset = 1'b0;

        // Directed cases, with hard-coded expectations alongside the model.
        run_txn("sra", 3'd5, 16'h1234, 8'h00, 8'h81, 0, 0, 1'b0);
        check("sra_wdata_const", 32'(mem_wdata), 32'hC0);
        check("sra_flags_const", 32'(f_out & 8'hD7), 32'h85);
        run_txn("srl", 3'd7, 16'h00A0, 8'h00, 8'h01, 0, 0, 1'b0);
        check("srl_flags_const", 32'(f_out & 8'hC5), 32'h45);
        run_txn("sla", 3'd4, 16'hBEEF, 8'h00, 8'h80, 0, 0, 1'b0);
        check("sla_flags_const", 32'(f_out & 8'h41), 32'h41);
        run_txn("rl_slow", 3'd2, 16'h4000, 8'h01, 8'h80, 2, 2, 1'b1);
        check("rl_wdata_const", 32'(mem_wdata), 32'h01);
        run_txn("op110", 3'd6, 16'h5555, 8'hA8, 8'h00, 0, 0, 1'b0);
        run_txn("rd_timeout", 3'd0, 16'h0102, 8'h29, 8'h3C, MW + 2, 0, 1'b0);
        run_txn("wr_timeout", 3'd1, 16'h0304, 8'hFF, 8'h3C, 1, MW + 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom);
            r_hl = 16'($urandom);
            r_f  = 8'($urandom);
            r_m  = 8'($urandom);
            r_rd = $urandom_range(0, MW + 1);
            r_wr = $urandom_range(0, MW + 1);
            run_txn($sformatf("rnd%0d", i), r_op, r_hl, r_f, r_m, r_rd, r_wr, 1'($urandom_range(0, 1)));
        end

        // Reset arriving while a write is outstanding.
        @(negedge clk);
        start = 1'b1; op = 3'd5; hl = 16'h7777; f_in = 8'h00;
        @(negedge clk);
        start = 1'b0;
        seen_wr = 1'b0;
        for (int k = 0; k < 20 && !seen_wr; k++) begin
            mem_ack = mem_rd;
            mem_rdata = 8'h55;
            if (mem_wr) begin
                seen_wr = 1'b1;
                mem_ack = 1'b1;
                reset = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("midwr_reached", 32'(seen_wr), 32'd1);
        @(negedge clk);
        check("midwr_mem_wr", 32'(mem_wr), 32'd0);
        check("midwr_busy", 32'(busy), 32'd0);
        check("midwr_done", 32'(done), 32'd0);
        check("midwr_f_out", 32'(f_out), 32'h00);
        check("midwr_addr", 32'(mem_addr), 32'h0000);

        // Reset outranks a simultaneous start.
        start = 1'b1; op = 3'd0;
        @(negedge clk);
        check("rst_vs_start", 32'(busy), 32'd0);
        reset = 1'b0; start = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);

        run_txn("after_rst", 3'd3, 16'hCAFE, 8'h01, 8'h02, 1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
